// File: rtl/fft_r2_stage_gen.sv
// Pipelined radix-2 DIF FFT stage: butterfly, twiddle rotation of the difference lane,
// then a delay-line commutator that regroups pairs for the following stage.
module fft_r2_stage_gen #(
  parameter int WIDTH    = 12,
  parameter int TW_WIDTH = 12,
  parameter int N_LOG2   = 4,
  parameter int STAGE    = 1,
  parameter int SCALE    = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [WIDTH-1:0]    in1_re,
  input  logic signed [WIDTH-1:0]    in1_im,
  input  logic signed [WIDTH-1:0]    in2_re,
  input  logic signed [WIDTH-1:0]    in2_im,
  output logic [N_LOG2-2:0]          tw_addr,
  input  logic signed [TW_WIDTH-1:0] tw_re,
  input  logic signed [TW_WIDTH-1:0] tw_im,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic signed [WIDTH-1:0]    out1_re,
  output logic signed [WIDTH-1:0]    out1_im,
  output logic signed [WIDTH-1:0]    out2_re,
  output logic signed [WIDTH-1:0]    out2_im
);

  localparam int CW    = N_LOG2 - 1;
  localparam int PW    = WIDTH + TW_WIDTH + 1;
  localparam int MBITS = N_LOG2 - 1 - STAGE;
  localparam bit LAST  = (STAGE == N_LOG2 - 1);
  localparam int DL2   = LAST ? 0 : (N_LOG2 - STAGE - 2);
  localparam int D     = 1 << DL2;

  localparam logic [CW-1:0]        TW_MASK = CW'((1 << MBITS) - 1);
  localparam logic signed [PW-1:0] MAXP    = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINP    = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0] RND     = PW'(1) <<< (TW_WIDTH - 2);
  localparam logic signed [WIDTH+1:0] ONE2 = {{(WIDTH+1){1'b0}}, 1'b1};

  generate
    if (STAGE < 0 || STAGE > N_LOG2 - 1 || N_LOG2 < 2 || WIDTH < 2 || TW_WIDTH < 2) begin : g_bad_param
      $error("fft_r2_stage_gen: STAGE must lie in 0..N_LOG2-1");
    end
  endgenerate

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [PW-1:0] x);
    if (x > MAXP)      sat_w = MAXP[WIDTH-1:0];
    else if (x < MINP) sat_w = MINP[WIDTH-1:0];
    else               sat_w = x[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH+1:0] ext2(input logic signed [WIDTH-1:0] a);
    return {{2{a[WIDTH-1]}}, a};
  endfunction

  // The +1 can push d = max-min one past range in scaled mode, so scaled results are clipped too
  function automatic logic signed [WIDTH-1:0] bfly(input logic signed [WIDTH+1:0] x);
    logic signed [WIDTH+1:0] r;
    r = (SCALE != 0) ? ((x + ONE2) >>> 1) : x;
    return sat_w({{(TW_WIDTH-1){r[WIDTH+1]}}, r});
  endfunction

  function automatic logic signed [PW-1:0] sxd(input logic signed [WIDTH-1:0] a);
    return {{(PW-WIDTH){a[WIDTH-1]}}, a};
  endfunction

  function automatic logic signed [PW-1:0] sxt(input logic signed [TW_WIDTH-1:0] a);
    return {{(PW-TW_WIDTH){a[TW_WIDTH-1]}}, a};
  endfunction

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt <= '0;
    else if (in_valid) cnt <= cnt + CW'(1);
  end

  assign tw_addr = (cnt & TW_MASK) << STAGE;

  logic signed [WIDTH+1:0] sum_re, sum_im, dif_re, dif_im;
  assign sum_re = ext2(in1_re) + ext2(in2_re);
  assign sum_im = ext2(in1_im) + ext2(in2_im);
  assign dif_re = ext2(in1_re) - ext2(in2_re);
  assign dif_im = ext2(in1_im) - ext2(in2_im);

  logic signed [WIDTH-1:0] p1_s_re, p1_s_im, p1_d_re, p1_d_im;
  logic                    p1_k0, p1_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_s_re <= '0;
      p1_s_im <= '0;
      p1_d_re <= '0;
      p1_d_im <= '0;
      p1_k0   <= 1'b0;
      p1_v    <= 1'b0;
    end else begin
      p1_s_re <= bfly(sum_re);
      p1_s_im <= bfly(sum_im);
      p1_d_re <= bfly(dif_re);
      p1_d_im <= bfly(dif_im);
      p1_k0   <= (tw_addr == '0);
      p1_v    <= in_valid;
    end
  end

  // The registered ROM returns tw one cycle after tw_addr, lining it up with stage-1 data
  logic signed [PW-1:0] prod_re, prod_im;
  assign prod_re = sxd(p1_d_re) * sxt(tw_re) - sxd(p1_d_im) * sxt(tw_im);
  assign prod_im = sxd(p1_d_re) * sxt(tw_im) + sxd(p1_d_im) * sxt(tw_re);

  logic signed [PW-1:0]    p2_re, p2_im;
  logic signed [WIDTH-1:0] p2_s_re, p2_s_im, p2_d_re, p2_d_im;
  logic                    p2_k0, p2_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_re   <= '0;
      p2_im   <= '0;
      p2_s_re <= '0;
      p2_s_im <= '0;
      p2_d_re <= '0;
      p2_d_im <= '0;
      p2_k0   <= 1'b0;
      p2_v    <= 1'b0;
    end else begin
      p2_re   <= prod_re;
      p2_im   <= prod_im;
      p2_s_re <= p1_s_re;
      p2_s_im <= p1_s_im;
      p2_d_re <= p1_d_re;
      p2_d_im <= p1_d_im;
      p2_k0   <= p1_k0;
      p2_v    <= p1_v;
    end
  end

  // W^0 = 1 is not representable in Q1.x, so k = 0 bypasses the multiplier exactly
  logic signed [PW-1:0] rnd_re, rnd_im;
  assign rnd_re = (p2_re + RND) >>> (TW_WIDTH - 1);
  assign rnd_im = (p2_im + RND) >>> (TW_WIDTH - 1);

  logic signed [WIDTH-1:0] x1_re, x1_im, x2_re, x2_im;
  logic                    v_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1_re <= '0;
      x1_im <= '0;
      x2_re <= '0;
      x2_im <= '0;
      v_c   <= 1'b0;
    end else begin
      x1_re <= p2_s_re;
      x1_im <= p2_s_im;
      x2_re <= p2_k0 ? p2_d_re : sat_w(rnd_re);
      x2_im <= p2_k0 ? p2_d_im : sat_w(rnd_im);
      v_c   <= p2_v;
    end
  end

  logic [2*WIDTH-1:0] o1, o2;
  logic               ov;

  generate
    if (LAST) begin : g_bypass
      assign o1 = {x1_re, x1_im};
      assign o2 = {x2_re, x2_im};
      assign ov = v_c;
    end else begin : g_comm
      logic [DL2:0]       ph;
      logic               sel;
      logic [2*WIDTH-1:0] x1_pk, x2_pk, x2d, m1;
      logic [2*WIDTH-1:0] dl1 [D];
      logic [2*WIDTH-1:0] dl2 [D];
      logic               dlv [D];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   ph <= '0;
        else if (v_c) ph <= ph + (DL2+1)'(1);
      end

      assign sel   = ph[DL2];
      assign x1_pk = {x1_re, x1_im};
      assign x2_pk = {x2_re, x2_im};
      assign x2d   = dl2[D-1];
      assign m1    = sel ? x2d : x1_pk;

      // Delay lines free-run so the trailing half-block drains during inter-frame gaps
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < D; i++) begin
            dl1[i] <= '0;
            dl2[i] <= '0;
            dlv[i] <= 1'b0;
          end
        end else begin
          dl1[0] <= m1;
          dl2[0] <= x2_pk;
          dlv[0] <= v_c;
          for (int i = 1; i < D; i++) begin
            dl1[i] <= dl1[i-1];
            dl2[i] <= dl2[i-1];
            dlv[i] <= dlv[i-1];
          end
        end
      end

      assign o1 = dl1[D-1];
      assign o2 = sel ? x1_pk : x2d;
      assign ov = dlv[D-1];
    end
  endgenerate

  logic [CW-1:0] obeat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  obeat <= '0;
    else if (ov) obeat <= obeat + CW'(1);
  end

  assign out_valid = ov;
  assign out_sop   = ov & (obeat == '0);
  assign out1_re   = o1[2*WIDTH-1:WIDTH];
  assign out1_im   = o1[WIDTH-1:0];
  assign out2_re   = o2[2*WIDTH-1:WIDTH];
  assign out2_im   = o2[WIDTH-1:0];

endmodule

// File: tb/tb_fft_r2_stage_gen.sv
// Directed vector bench for fft_r2_stage_gen (N=16, stage 1): a scaled instance and an
// unscaled instance share the stimulus and a registered twiddle ROM model.
module tb_fft_r2_stage_gen;

  typedef struct {
    logic signed [11:0] i1r, i1i, i2r, i2i;
    logic [2:0]         tw;
    logic [47:0]        exp_main;
    logic [47:0]        exp_alt;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic signed [11:0] in1_re = '0, in1_im = '0, in2_re = '0, in2_im = '0;
  logic signed [11:0] tw_re = '0, tw_im = '0;
  logic [2:0]         tw_addr, s_tw_addr;
  logic               out_valid, out_sop, s_out_valid, s_out_sop;
  logic signed [11:0] out1_re, out1_im, out2_re, out2_im;
  logic signed [11:0] s_out1_re, s_out1_im, s_out2_re, s_out2_im;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int c0 = 0;

  vec_t tbl [8];
  vec_t tbl_s [8];

  logic [47:0] cap_d [$];
  logic        cap_sop [$];
  int          cap_cyc [$];
  logic [47:0] cap_s [$];
  logic        cap_ssop [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_r2_stage_gen #(.WIDTH(12), .TW_WIDTH(12), .N_LOG2(4), .STAGE(1), .SCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1_re(in1_re), .in1_im(in1_im), .in2_re(in2_re), .in2_im(in2_im),
    .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_sop(out_sop),
    .out1_re(out1_re), .out1_im(out1_im), .out2_re(out2_re), .out2_im(out2_im)
  );

  fft_r2_stage_gen #(.WIDTH(12), .TW_WIDTH(12), .N_LOG2(4), .STAGE(1), .SCALE(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .in1_re(in1_re), .in1_im(in1_im), .in2_re(in2_re), .in2_im(in2_im),
    .tw_addr(s_tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(s_out_valid), .out_sop(s_out_sop),
    .out1_re(s_out1_re), .out1_im(s_out1_im), .out2_re(s_out2_re), .out2_im(s_out2_im)
  );

  // W_16^k = cos - j sin in Q1.11, with 1.0 clipped to 2047
  function automatic logic [23:0] rom(input logic [2:0] k);
    case (k)
      3'd0:    return {12'sd2047, 12'sd0};
      3'd1:    return {12'sd1892, -12'sd784};
      3'd2:    return {12'sd1448, -12'sd1448};
      3'd3:    return {12'sd784, -12'sd1892};
      3'd4:    return {12'sd0, -12'sd2048};
      3'd5:    return {-12'sd784, -12'sd1892};
      3'd6:    return {-12'sd1448, -12'sd1448};
      default: return {-12'sd1892, -12'sd784};
    endcase
  endfunction

  always @(posedge clk) {tw_re, tw_im} <= rom(tw_addr);

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      cap_d.push_back({out1_re, out1_im, out2_re, out2_im});
      cap_sop.push_back(out_sop);
      cap_cyc.push_back(cyc);
    end
    if (rst_n && s_out_valid) begin
      cap_s.push_back({s_out1_re, s_out1_im, s_out2_re, s_out2_im});
      cap_ssop.push_back(s_out_sop);
    end
  end

  function automatic logic [47:0] pk(input int a, input int b, input int c, input int d);
    return {12'(a), 12'(b), 12'(c), 12'(d)};
  endfunction

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int k, input logic [47:0] e);
    vec_t v;
    v.i1r = 12'(a);
    v.i1i = 12'(b);
    v.i2r = 12'(c);
    v.i2i = 12'(d);
    v.tw = 3'(k);
    v.exp_main = e;
    v.exp_alt = '0;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    @(negedge clk);
    in_valid = 1'b1;
    in1_re = v.i1r;
    in1_im = v.i1i;
    in2_re = v.i2r;
    in2_im = v.i2i;
    checkOutput({tag, " tw_addr"}, 48'(tw_addr), 48'(v.tw));
    checkOutput({tag, " sat tw_addr"}, 48'(s_tw_addr), 48'(v.tw));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in1_re = '0;
      in1_im = '0;
      in2_re = '0;
      in2_im = '0;
    end
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, " out_valid"}, 48'(out_valid), 48'd0);
    checkOutput({tag, " out_sop"}, 48'(out_sop), 48'd0);
    checkOutput({tag, " outputs"}, {out1_re, out1_im, out2_re, out2_im}, 48'd0);
    checkOutput({tag, " tw_addr"}, 48'(tw_addr), 48'd0);
  endtask

  task automatic clearCaps();
    cap_d.delete();
    cap_sop.delete();
    cap_cyc.delete();
    cap_s.delete();
    cap_ssop.delete();
  endtask

  initial begin
    tbl[0] = mk(100, 0, 20, 0, 0, pk(60, 0, 200, 0));
    tbl[1] = mk(64, 64, 0, 0, 2, pk(32, 32, 32, -32));
    tbl[2] = mk(300, 100, 100, -100, 4, pk(40, 0, 100, -100));
    tbl[3] = mk(64, -64, 0, 0, 6, pk(45, 0, -45, 0));
    tbl[4] = mk(1500, -1500, -1500, 1500, 0, pk(0, 0, 5, -10));
    tbl[5] = mk(0, 0, -64, -64, 2, pk(-32, -32, 5, 5));
    tbl[6] = mk(10, -20, 0, 0, 4, pk(1500, -1500, -10, -5));
    tbl[7] = mk(7, 3, 3, 7, 6, pk(45, 0, -3, 0));

    tbl_s[0] = mk(2047, 0, 2047, 0, 0, pk(2047, 0, 60, 0));
    tbl_s[0].exp_alt = pk(2047, 0, 120, 0);
    tbl_s[1] = mk(-2048, -2048, -2048, -2048, 2, pk(-2048, -2048, 0, 0));
    tbl_s[1].exp_alt = pk(-2048, -2048, 0, 0);
    tbl_s[2] = mk(100, 0, 20, 0, 4, pk(0, 0, 0, -40));
    tbl_s[2].exp_alt = pk(0, 0, 0, -80);
    for (int b = 3; b < 8; b++) tbl_s[b] = mk(0, 0, 0, 0, (2 * b) % 8, pk(0, 0, 0, 0));

    // Reset state, then a partial frame interrupted by an asynchronous reset
    repeat (2) @(negedge clk);
    checkIdle("reset start");
    rst_n = 1'b1;
    for (int b = 0; b < 6; b++) begin
      applyStimulus(tbl[b], $sformatf("A beat %0d", b));
      if (b == 0) c0 = cyc;
    end
    idle(1);
    #2;
    checkOutput("A out_valid before reset", 48'(out_valid), 48'd1);
    rst_n = 1'b0;
    #1;
    checkIdle("A mid-frame reset");
    checkOutput("A beats seen", 48'(cap_d.size()), 48'd2);
    if (cap_d.size() >= 2) begin
      checkOutput("A latency", 48'(cap_cyc[0] - c0), 48'd5);
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("A out beat %0d", i), cap_d[i], tbl[i].exp_main);
        checkOutput($sformatf("A sop beat %0d", i), 48'(cap_sop[i]), 48'(i == 0));
      end
    end
    idle(2);
    rst_n = 1'b1;
    clearCaps();

    // Two back-to-back frames, a 7-cycle gap, then a third frame
    for (int f = 0; f < 3; f++) begin
      if (f == 2) idle(7);
      for (int b = 0; b < 8; b++) applyStimulus(tbl[b], $sformatf("B f%0d beat %0d", f, b));
    end
    idle(15);
    checkOutput("B beats seen", 48'(cap_d.size()), 48'd24);
    for (int i = 0; i < cap_d.size() && i < 24; i++) begin
      checkOutput($sformatf("B out beat %0d", i), cap_d[i], tbl[i % 8].exp_main);
      checkOutput($sformatf("B sop beat %0d", i), 48'(cap_sop[i]), 48'(i % 8 == 0));
      if (i > 0)
        checkOutput($sformatf("B spacing beat %0d", i), 48'(cap_cyc[i] - cap_cyc[i-1]),
                    48'((i == 16) ? 8 : 1));
    end
    clearCaps();

    // Saturation frame: both scaling modes side by side
    for (int b = 0; b < 8; b++) applyStimulus(tbl_s[b], $sformatf("S beat %0d", b));
    idle(15);
    checkOutput("S beats seen", 48'(cap_d.size()), 48'd8);
    checkOutput("S sat beats seen", 48'(cap_s.size()), 48'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < cap_d.size())
        checkOutput($sformatf("S scaled beat %0d", i), cap_d[i], tbl_s[i].exp_main);
      if (i < cap_s.size()) begin
        checkOutput($sformatf("S unscaled beat %0d", i), cap_s[i], tbl_s[i].exp_alt);
        checkOutput($sformatf("S unscaled sop %0d", i), 48'(cap_ssop[i]), 48'(i == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
